// File: rtl/sr_bist_harness.sv
// On-chip sequencer/checker for the top_sr dataflow: issues config tokens, streams the
// stimulus ROM into the DUT, checks DUT output against a golden ROM and reports status.
module sr_bist_harness #(
  parameter int DATA_W  = 8,
  parameter int ALPHA_W = 3,
  parameter int SIZE_W  = 7,
  parameter int TAP     = 8,
  parameter int ADDR_W  = 13,
  parameter int ERR_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZE_W-1:0]   cfg_size,
  input  logic [ALPHA_W-1:0]  cfg_v_alpha,
  input  logic [ALPHA_W-1:0]  cfg_h_alpha,
  input  logic [7:0]          bp_mask,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                cfg_err,
  output logic                timed_out,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_idx,
  output logic                stim_rd,
  output logic [ADDR_W-1:0]   stim_addr,
  input  logic [DATA_W-1:0]   stim_data,
  output logic                gold_rd,
  output logic [ADDR_W-1:0]   gold_addr,
  input  logic [DATA_W-1:0]   gold_data,
  output logic [ALPHA_W:0]    v_alpha_din,
  output logic                v_alpha_write,
  output logic [ALPHA_W:0]    h_alpha_din,
  output logic                h_alpha_write,
  output logic [SIZE_W:0]     ext_size_din,
  output logic                ext_size_write,
  output logic [DATA_W:0]     in_din,
  output logic                in_write,
  input  logic                in_full,
  input  logic [DATA_W:0]     out_din,
  input  logic                out_write,
  output logic                out_full
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic size_ok(input logic [SIZE_W-1:0] s);
    case (s)
      SIZE_W'(4), SIZE_W'(8), SIZE_W'(16), SIZE_W'(32), SIZE_W'(64): size_ok = 1'b1;
      default: size_ok = 1'b0;
    endcase
  endfunction

  function automatic logic alpha_ok(input logic [ALPHA_W-1:0] a);
    alpha_ok = ~a[0] & (a <= ALPHA_W'(6));
  endfunction

  state_t              state_q, state_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [ALPHA_W-1:0]  va_q, va_d, ha_q, ha_d;
  logic [ADDR_W-1:0]   n_in_q, n_in_d, n_out_q, n_out_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0]   out_idx_q, out_idx_d, cap_idx_q, cap_idx_d, first_err_q, first_err_d;
  logic                valid_q, valid_d, fresh_q, fresh_d;
  logic                cmp_pend_q, cmp_pend_d, all_cmp_q, all_cmp_d;
  logic                cfg_err_q, cfg_err_d, timed_out_q, timed_out_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W:0]     cap_q, cap_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [2:0]          k_q, k_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic                busy_s, active_s, in_write_s, rd_en_s, out_full_s, out_acc_s;
  logic                mismatch_s, last_cmp_s, timeout_s, cfg_ok_s;
  logic [DATA_W-1:0]   pix_s;
  logic [SIZE_W-1:0]   ext_s;
  logic [ADDR_W-1:0]   ext_w_s, size_w_s;
  logic [WD_W-1:0]     wd_inc_s;

  // Datapath handshakes and comparison; pix_s bypasses the hold register on the cycle ROM data lands.
  always_comb begin
    busy_s     = (state_q == S_CFG) | (state_q == S_FEED) | (state_q == S_DRAIN);
    active_s   = (state_q == S_FEED) | (state_q == S_DRAIN);
    pix_s      = fresh_q ? stim_data : hold_q;
    in_write_s = valid_q & ~in_full & (state_q == S_FEED);
    rd_en_s    = ((state_q == S_CFG) | (state_q == S_FEED)) & (rd_addr_q != n_in_q)
                 & (~valid_q | in_write_s);
    out_full_s = busy_s & bp_mask[k_q];
    out_acc_s  = busy_s & out_write & ~out_full_s & (out_idx_q < n_out_q);
    mismatch_s = busy_s & cmp_pend_q & (cap_q[DATA_W] | (cap_q[DATA_W-1:0] != gold_data));
    last_cmp_s = busy_s & cmp_pend_q & (cap_idx_q == (n_out_q - ONE_A));
    wd_inc_s   = wd_q + WD_W'(1);
    timeout_s  = active_s & ~(in_write_s | out_acc_s) & (wd_inc_s == WD_W'(TIMEOUT));
    ext_s      = cfg_size + SIZE_W'(TAP - 1);
    ext_w_s    = {{(ADDR_W-SIZE_W){1'b0}}, ext_s};
    size_w_s   = {{(ADDR_W-SIZE_W){1'b0}}, cfg_size};
    cfg_ok_s   = size_ok(cfg_size) & alpha_ok(cfg_v_alpha) & alpha_ok(cfg_h_alpha);
  end

  // Next-state and run bookkeeping; a start in IDLE/DONE overrides everything with fresh run state.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    va_d        = va_q;
    ha_d        = ha_q;
    n_in_d      = n_in_q;
    n_out_d     = n_out_q;
    cfg_err_d   = cfg_err_q;
    timed_out_d = timed_out_q;
    hold_d      = pix_s;
    fresh_d     = rd_en_s;
    valid_d     = rd_en_s | (valid_q & ~in_write_s);
    rd_addr_d   = rd_en_s ? (rd_addr_q + ONE_A) : rd_addr_q;
    in_cnt_d    = in_write_s ? (in_cnt_q + ONE_A) : in_cnt_q;
    k_d         = busy_s ? (k_q + 3'd1) : k_q;
    cmp_pend_d  = out_acc_s;
    cap_d       = out_acc_s ? out_din : cap_q;
    cap_idx_d   = out_acc_s ? out_idx_q : cap_idx_q;
    out_idx_d   = out_acc_s ? (out_idx_q + ONE_A) : out_idx_q;
    all_cmp_d   = all_cmp_q | last_cmp_s;
    wd_d        = (active_s & ~(in_write_s | out_acc_s)) ? wd_inc_s : '0;
    if (mismatch_s) begin
      err_d       = (err_q == {ERR_W{1'b1}}) ? err_q : (err_q + ERR_W'(1));
      first_err_d = (err_q == '0) ? cap_idx_q : first_err_q;
    end else begin
      err_d       = err_q;
      first_err_d = first_err_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = cfg_ok_s ? S_CFG : S_DONE;
          size_d      = cfg_size;
          va_d        = cfg_v_alpha;
          ha_d        = cfg_h_alpha;
          n_in_d      = ext_w_s * ext_w_s;
          n_out_d     = size_w_s * size_w_s;
          cfg_err_d   = ~cfg_ok_s;
          timed_out_d = 1'b0;
          err_d       = '0;
          first_err_d = '0;
          valid_d     = 1'b0;
          fresh_d     = 1'b0;
          rd_addr_d   = '0;
          in_cnt_d    = '0;
          out_idx_d   = '0;
          cap_idx_d   = '0;
          cap_d       = '0;
          cmp_pend_d  = 1'b0;
          all_cmp_d   = 1'b0;
          k_d         = 3'd0;
          wd_d        = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_CFG: state_d = S_FEED;
      S_FEED: begin
        if (timeout_s) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else if (in_write_s && (in_cnt_q == (n_in_q - ONE_A))) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FEED;
        end
      end
      S_DRAIN: begin
        if (timeout_s) begin
          state_d     = S_DONE;
          timed_out_d = 1'b1;
        end else if (last_cmp_s || all_cmp_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      va_q        <= '0;
      ha_q        <= '0;
      n_in_q      <= '0;
      n_out_q     <= '0;
      rd_addr_q   <= '0;
      in_cnt_q    <= '0;
      out_idx_q   <= '0;
      cap_idx_q   <= '0;
      first_err_q <= '0;
      valid_q     <= 1'b0;
      fresh_q     <= 1'b0;
      cmp_pend_q  <= 1'b0;
      all_cmp_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      timed_out_q <= 1'b0;
      hold_q      <= '0;
      cap_q       <= '0;
      err_q       <= '0;
      k_q         <= 3'd0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      va_q        <= va_d;
      ha_q        <= ha_d;
      n_in_q      <= n_in_d;
      n_out_q     <= n_out_d;
      rd_addr_q   <= rd_addr_d;
      in_cnt_q    <= in_cnt_d;
      out_idx_q   <= out_idx_d;
      cap_idx_q   <= cap_idx_d;
      first_err_q <= first_err_d;
      valid_q     <= valid_d;
      fresh_q     <= fresh_d;
      cmp_pend_q  <= cmp_pend_d;
      all_cmp_q   <= all_cmp_d;
      cfg_err_q   <= cfg_err_d;
      timed_out_q <= timed_out_d;
      hold_q      <= hold_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      k_q         <= k_d;
      wd_q        <= wd_d;
    end
  end

  assign busy           = busy_s;
  assign done           = (state_q == S_DONE);
  assign pass           = (state_q == S_DONE) & ~cfg_err_q & ~timed_out_q & (err_q == '0);
  assign cfg_err        = cfg_err_q;
  assign timed_out      = timed_out_q;
  assign err_count      = err_q;
  assign first_err_idx  = first_err_q;
  assign stim_rd        = rd_en_s;
  assign stim_addr      = rd_en_s ? rd_addr_q : '0;
  assign gold_rd        = out_acc_s;
  assign gold_addr      = out_acc_s ? out_idx_q : '0;
  assign v_alpha_write  = (state_q == S_CFG);
  assign h_alpha_write  = (state_q == S_CFG);
  assign ext_size_write = (state_q == S_CFG);
  assign v_alpha_din    = (state_q == S_CFG) ? {1'b1, va_q} : '0;
  assign h_alpha_din    = (state_q == S_CFG) ? {1'b1, ha_q} : '0;
  assign ext_size_din   = (state_q == S_CFG) ? {1'b1, size_q + SIZE_W'(TAP - 1)} : '0;
  assign in_write       = in_write_s;
  assign in_din         = valid_q ? {1'b0, pix_s} : '0;
  assign out_full       = out_full_s;

endmodule

// File: tb/tb_sr_bist_harness.sv
// Directed bench for sr_bist_harness: ROM models, a late-emitting DUT output model and a vector table.
module tb_sr_bist_harness;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  cfg_size = 7'd0;
  logic [2:0]  cfg_v_alpha = 3'd0, cfg_h_alpha = 3'd0;
  logic [7:0]  bp_mask = 8'd0;
  logic        busy, done, pass, cfg_err, timed_out;
  logic [15:0] err_count;
  logic [12:0] first_err_idx, stim_addr, gold_addr;
  logic        stim_rd, gold_rd;
  logic [7:0]  stim_data = 8'd0, gold_data = 8'd0;
  logic [3:0]  v_alpha_din, h_alpha_din;
  logic        v_alpha_write, h_alpha_write, ext_size_write;
  logic [7:0]  ext_size_din;
  logic [8:0]  in_din;
  logic        in_write;
  logic        in_full = 1'b0;
  logic [8:0]  out_din = 9'd0;
  logic        out_write = 1'b0;
  logic        out_full;

  sr_bist_harness dut (
    .clk(clk), .rst(rst), .start(start), .cfg_size(cfg_size),
    .cfg_v_alpha(cfg_v_alpha), .cfg_h_alpha(cfg_h_alpha), .bp_mask(bp_mask),
    .busy(busy), .done(done), .pass(pass), .cfg_err(cfg_err), .timed_out(timed_out),
    .err_count(err_count), .first_err_idx(first_err_idx),
    .stim_rd(stim_rd), .stim_addr(stim_addr), .stim_data(stim_data),
    .gold_rd(gold_rd), .gold_addr(gold_addr), .gold_data(gold_data),
    .v_alpha_din(v_alpha_din), .v_alpha_write(v_alpha_write),
    .h_alpha_din(h_alpha_din), .h_alpha_write(h_alpha_write),
    .ext_size_din(ext_size_din), .ext_size_write(ext_size_write),
    .in_din(in_din), .in_write(in_write), .in_full(in_full),
    .out_din(out_din), .out_write(out_write), .out_full(out_full)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] stim_val(input int i);
    stim_val = 8'((i * 13 + 5) & 255);
  endfunction

  function automatic logic [7:0] gold_val(input int j);
    gold_val = 8'((j * 29 + 11) & 255) ^ 8'h3C;
  endfunction

  logic [7:0] stim_mem [0:8191];
  logic [7:0] gold_mem [0:8191];

  always @(posedge clk) begin
    if (stim_rd) stim_data <= stim_mem[stim_addr];
    if (gold_rd) gold_data <= gold_mem[gold_addr];
  end

  typedef struct {
    int size; int va; int ha; int bp; int mode; int ek; int ei; int restart;
    int pass; int cfg; int err; int first; int nin; int nout;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Monitor/model state
  int cyc = 0, in_cnt = 0, in_bad = 0, m_idx = 0, m_nin = 0, m_nout = 0;
  int mode = 0, err_kind = 0, err_idx = -1;
  int tok_cnt = 0, tok_bad = 0, tok_cyc = 0, start_cyc = 0, done_cyc = 0;
  int last_out_cyc = 0, last_acc_cyc = 0, bad_acc_cyc = 0, err_cyc = 0, first_addr = -1;
  bit done_seen = 1'b0, err_seen = 1'b0, addr_seen = 1'b0;
  logic [3:0] v_tok = 4'd0, h_tok = 4'd0;
  logic [7:0] e_tok = 8'd0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive DUT-side stream inputs on the falling edge, then observe what the next rising edge accepts.
  initial forever begin
    @(negedge clk);
    case (mode)
      1: in_full = (cyc % 3 == 0);
      2: in_full = (in_cnt >= 100);
      default: in_full = 1'b0;
    endcase
    if (m_idx < m_nout && in_cnt > m_nin - m_nout + m_idx) begin
      out_write = 1'b1;
      out_din = {1'b0, gold_val(m_idx)};
      if (err_kind == 1 && m_idx == err_idx) out_din[7:0] = out_din[7:0] ^ 8'h5A;
      if (err_kind == 2 && m_idx == err_idx) out_din[8] = 1'b1;
    end else begin
      out_write = 1'b0;
      out_din = 9'd0;
    end
    #1;
    if (!rst || (start && !busy)) begin
      in_cnt = 0; in_bad = 0; m_idx = 0; tok_cnt = 0; tok_bad = 0;
      done_seen = 1'b0; err_seen = 1'b0; addr_seen = 1'b0; first_addr = -1;
      start_cyc = cyc;
    end else begin
      if (in_write) begin
        if (in_din !== {1'b0, stim_val(in_cnt)}) in_bad++;
        in_cnt++;
        last_acc_cyc = cyc;
      end
      if (stim_rd && !addr_seen) begin
        addr_seen = 1'b1;
        first_addr = int'(stim_addr);
      end
      if (out_write && !out_full) begin
        if (m_idx == err_idx) bad_acc_cyc = cyc;
        m_idx++;
        last_out_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (v_alpha_write || h_alpha_write || ext_size_write) begin
        if (!(v_alpha_write && h_alpha_write && ext_size_write)) tok_bad++;
        tok_cnt++;
        tok_cyc = cyc;
        v_tok = v_alpha_din; h_tok = h_alpha_din; e_tok = ext_size_din;
      end
      if (err_count != 16'd0 && !err_seen) begin
        err_seen = 1'b1;
        err_cyc = cyc;
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic launch(input vec_t v);
    cfg_size = 7'(v.size); cfg_v_alpha = 3'(v.va); cfg_h_alpha = 3'(v.ha);
    bp_mask = 8'(v.bp); mode = v.mode; err_kind = v.ek; err_idx = v.ei;
    m_nin = v.nin; m_nout = v.nout;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit restart, input string tag);
    for (int c = 0; c < budget && !done_seen; c++) begin
      @(negedge clk);
      start = (restart && c == 50);
    end
    start = 1'b0;
    chk({tag, "/done_reached"}, int'(done_seen), 1);
    @(negedge clk); #2;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    launch(v);
    wait_done(20000, v.restart != 0, tag);
    chk({tag, "/pass"}, int'(pass), v.pass);
    chk({tag, "/cfg_err"}, int'(cfg_err), v.cfg);
    chk({tag, "/timed_out"}, int'(timed_out), 0);
    chk({tag, "/err_count"}, int'(err_count), v.err);
    chk({tag, "/first_err_idx"}, int'(first_err_idx), v.first);
    chk({tag, "/n_in"}, in_cnt, v.nin);
    chk({tag, "/n_out"}, m_idx, v.nout);
    chk({tag, "/in_order"}, in_bad, 0);
    chk({tag, "/busy_low"}, int'(busy), 0);
    chk({tag, "/tok_cycles"}, tok_cnt, (v.cfg != 0) ? 0 : 1);
    chk({tag, "/tok_together"}, tok_bad, 0);
    if (v.cfg != 0) begin
      chk({tag, "/cfg_done_lat"}, done_cyc - start_cyc, 1);
    end else begin
      chk({tag, "/v_tok"}, int'(v_tok), 8 + v.va);
      chk({tag, "/h_tok"}, int'(h_tok), 8 + v.ha);
      chk({tag, "/e_tok"}, int'(e_tok), 128 + v.size + 7);
      chk({tag, "/tok_lat"}, tok_cyc - start_cyc, 1);
      chk({tag, "/first_stim_addr"}, first_addr, 0);
      chk({tag, "/done_lat"}, done_cyc - last_out_cyc, 2);
    end
    if (v.err != 0) chk({tag, "/err_lat"}, err_cyc - bad_acc_cyc, 2);
  endtask

  vec_t vecs [9];
  vec_t tv;
  int   d;
  logic any_out;

  initial begin
    for (int i = 0; i < 8192; i++) begin
      stim_mem[i] = stim_val(i);
      gold_mem[i] = gold_val(i);
    end
    //          size va ha bp     md ek ei  rs pass cfg err first nin   nout
    vecs[0] = '{16,  2, 2, 8'h00, 0, 0, -1, 0, 1,   0,  0,  0,    529,  256};
    vecs[1] = '{16,  2, 2, 8'h00, 0, 1, 37, 0, 0,   0,  1,  37,   529,  256};
    vecs[2] = '{16,  2, 2, 8'hAA, 1, 0, -1, 1, 1,   0,  0,  0,    529,  256};
    vecs[3] = '{12,  2, 2, 8'h00, 0, 0, -1, 0, 0,   1,  0,  0,    0,    0};
    vecs[4] = '{16,  3, 2, 8'h00, 0, 0, -1, 0, 0,   1,  0,  0,    0,    0};
    vecs[5] = '{4,   0, 6, 8'h00, 0, 0, -1, 0, 1,   0,  0,  0,    121,  16};
    vecs[6] = '{8,   4, 4, 8'hF0, 1, 1, 0,  0, 0,   0,  1,  0,    225,  64};
    vecs[7] = '{4,   6, 0, 8'h55, 0, 2, 15, 0, 0,   0,  1,  15,   121,  16};
    vecs[8] = '{64,  2, 4, 8'h00, 0, 0, -1, 0, 1,   0,  0,  0,    5041, 4096};

    repeat (3) @(negedge clk);
    #1;
    any_out = |{busy, done, pass, cfg_err, timed_out, err_count, first_err_idx, stim_rd,
                stim_addr, gold_rd, gold_addr, v_alpha_din, v_alpha_write, h_alpha_din,
                h_alpha_write, ext_size_din, ext_size_write, in_din, in_write, out_full};
    chk("reset_outputs_zero", int'(any_out), 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Input side stalls permanently at pixel 100: watchdog must abort.
    tv = vecs[0];
    tv.mode = 2;
    launch(tv);
    wait_done(8000, 1'b0, "timeout");
    chk("timeout/timed_out", int'(timed_out), 1);
    chk("timeout/pass", int'(pass), 0);
    chk("timeout/n_in", in_cnt, 100);
    d = done_cyc - last_acc_cyc;
    chk("timeout/idle_window", int'(d >= 4096 && d <= 4098), 1);
    mode = 0;

    // Reset in the middle of feeding, then a clean rerun.
    launch(vecs[0]);
    for (int c = 0; c < 2000 && in_cnt < 200; c++) @(negedge clk);
    chk("rst_mid/reached_200", int'(in_cnt >= 200), 1);
    rst = 1'b0;
    for (int r = 0; r < 3; r++) begin
      #1;
      any_out = |{busy, done, pass, cfg_err, timed_out, err_count, first_err_idx, stim_rd,
                  stim_addr, gold_rd, gold_addr, v_alpha_din, v_alpha_write, h_alpha_din,
                  h_alpha_write, ext_size_din, ext_size_write, in_din, in_write, out_full};
      chk($sformatf("rst_mid/outputs_zero_%0d", r), int'(any_out), 0);
      @(negedge clk);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_vec(vecs[0], "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
